// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the 32-entry flop-bank register file: arbitrates writeback
// against the auxiliary port, decodes the one-hot enable, and sweeps r1..r31 to zero.
module regfile_write_sched #(
   parameter int NREGS  = 32,
   parameter int AW     = 5,
   parameter int DW     = 32,
   parameter int STARVE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [AW-1:0]    wb_addr,
   input  logic [DW-1:0]    wb_data,
   input  logic             aux_valid,
   output logic             aux_ready,
   input  logic [AW-1:0]    aux_addr,
   input  logic [DW-1:0]    aux_data,
   input  logic             clr_req,
   output logic [NREGS-1:0] en,
   output logic [DW-1:0]    wdata,
   output logic             busy
);

   localparam int SW = $clog2(STARVE + 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_CLEAR
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    scnt_q, scnt_d;
   logic [NREGS-1:0] en_q, en_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic             busy_q;
   logic             force_aux;
   logic             wb_hs;
   logic             aux_hs;

   // Bit 0 is always masked: r0 is hardwired zero and must never be written.
   function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] a);
      reg_onehot = (NREGS'(1) << a) & ~NREGS'(1);
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      scnt_d    = scnt_q;
      en_d      = '0;
      wdata_d   = wdata_q;
      wb_ready  = 1'b0;
      aux_ready = 1'b0;
      wb_hs     = 1'b0;
      aux_hs    = 1'b0;
      force_aux = (scnt_q == SW'(STARVE));
      case (state_q)
         S_RUN: begin
            if (clr_req) begin
               state_d = S_CLEAR;
            end else begin
               wb_ready  = !force_aux;
               aux_ready = force_aux | !wb_valid;
            end
            // The ready equations make the two handshakes mutually exclusive.
            wb_hs  = wb_valid & wb_ready;
            aux_hs = aux_valid & aux_ready;
            if (wb_hs) begin
               en_d    = reg_onehot(wb_addr);
               wdata_d = wb_data;
            end else if (aux_hs) begin
               en_d    = reg_onehot(aux_addr);
               wdata_d = aux_data;
            end
            if (aux_hs || !aux_valid) begin
               scnt_d = '0;
            end else if (!force_aux) begin
               scnt_d = scnt_q + SW'(1);
            end
         end
         default: begin
            en_d    = reg_onehot(cnt_q);
            wdata_d = '0;
            if (cnt_q == AW'(NREGS - 1)) begin
               state_d = S_RUN;
               cnt_d   = AW'(1);
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
      endcase
   end

   // busy lags the state by one cycle so it covers the final enable pulse of a sweep.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_INIT;
         cnt_q   <= AW'(1);
         scnt_q  <= '0;
         en_q    <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scnt_q  <= scnt_d;
         en_q    <= en_d;
         wdata_q <= wdata_d;
         busy_q  <= (state_q != S_RUN);
      end
   end

   assign en    = en_q;
   assign wdata = wdata_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: directed scenarios followed by random traffic,
// all checked against a behavioural model of the write scheduler.
module tb_regfile_write_sched;

   localparam int NREGS  = 32;
   localparam int AW     = 5;
   localparam int DW     = 32;
   localparam int STARVE = 4;

   logic             clk;
   logic             reset;
   logic             wb_valid;
   logic             wb_ready;
   logic [AW-1:0]    wb_addr;
   logic [DW-1:0]    wb_data;
   logic             aux_valid;
   logic             aux_ready;
   logic [AW-1:0]    aux_addr;
   logic [DW-1:0]    aux_data;
   logic             clr_req;
   logic [NREGS-1:0] en;
   logic [DW-1:0]    wdata;
   logic             busy;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: sweeping flag with next register to clear, consecutive-denial count,
   // expected registered outputs.
   bit          m_sweep;
   int          m_idx;
   int          m_starve;
   bit          m_busy;
   logic [31:0] m_en;
   logic [31:0] m_wdata;
   bit          g_wb_stall;
   bit          g_aux_stall;
   int          wb_writes;
   int          aux_writes;

   regfile_write_sched #(
      .NREGS(NREGS), .AW(AW), .DW(DW), .STARVE(STARVE)
   ) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
      .clr_req(clr_req), .en(en), .wdata(wdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit r, input bit wv, input int wa, input logic [31:0] wd,
                        input bit av, input int aa, input logic [31:0] ad, input bit c);
      bit ewr, ear, gw, ga;
      reset     = r;
      wb_valid  = wv;
      wb_addr   = wa[AW-1:0];
      wb_data   = wd;
      aux_valid = av;
      aux_addr  = aa[AW-1:0];
      aux_data  = ad;
      clr_req   = c;
      #2;
      ewr = 0;
      ear = 0;
      if (!m_sweep && !c) begin
         ewr = (m_starve < STARVE);
         ear = (m_starve >= STARVE) || !wv;
      end
      if (r) begin
         chk("wb_ready", {31'd0, wb_ready}, {31'd0, ewr});
         chk("aux_ready", {31'd0, aux_ready}, {31'd0, ear});
      end
      g_wb_stall  = wv && !ewr;
      g_aux_stall = av && !ear;
      if (!r) begin
         m_sweep = 1; m_idx = 1; m_starve = 0; m_en = 0; m_wdata = 0; m_busy = 1;
      end else if (m_sweep) begin
         m_busy  = 1;
         m_en    = 32'd1 << m_idx;
         m_wdata = 0;
         m_idx++;
         if (m_idx == NREGS) begin
            m_sweep = 0;
            m_idx   = 1;
         end
      end else begin
         m_busy = 0;
         m_en   = 0;
         gw = wv && ewr;
         ga = av && ear;
         if (gw) begin
            m_en    = (wa == 0) ? 32'd0 : (32'd1 << wa);
            m_wdata = wd;
            wb_writes++;
         end else if (ga) begin
            m_en    = (aa == 0) ? 32'd0 : (32'd1 << aa);
            m_wdata = ad;
            aux_writes++;
         end
         if (c) m_sweep = 1;
         if (ga || !av) m_starve = 0;
         else if (m_starve < STARVE) m_starve++;
      end
      @(posedge clk);
      #1;
      chk("en", en, m_en);
      chk("wdata", wdata, m_wdata);
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit          wv, av, c, r;
      int          wa, aa;
      logic [31:0] wd, ad;

      wb_writes  = 0;
      aux_writes = 0;
      @(posedge clk);
      #1;

      // Reset held three cycles
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_en_zero", en, 32'd0);

      // Power-on sweep: 31 enable pulses, then busy drops
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      chk("init_first_pulse", en, 32'h0000_0002);
      idle(30);
      chk("init_last_pulse", en, 32'h8000_0000);
      chk("busy_during_last", {31'd0, busy}, 32'd1);
      idle(1);
      chk("busy_after_sweep", {31'd0, busy}, 32'd0);

      // Single writeback
      cycle(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
      chk("wb5_en", en, 32'h0000_0020);
      chk("wb5_data", wdata, 32'hDEAD_BEEF);
      idle(1);
      chk("wb5_en_drop", en, 32'd0);
      chk("wb5_data_hold", wdata, 32'hDEAD_BEEF);

      // Contention: aux forced through on every fifth cycle
      for (int i = 0; i < 10; i++) cycle(1, 1, 3, 32'h3333_0000 + i, 1, 7, 32'h7777_0000, 0);
      chk("starve_aux_en", en, 32'h0000_0080);
      idle(1);

      // r0 write is accepted but never enabled
      cycle(1, 1, 0, 32'h1234, 0, 0, 0, 0);
      chk("r0_en", en, 32'd0);
      idle(1);
      cycle(1, 1, 1, 32'h5678, 0, 0, 0, 0);
      chk("r1_en", en, 32'h0000_0002);

      // Clear request preempts a writeback; wb accepted right after the sweep
      cycle(1, 1, 9, 32'hAAAA_5555, 0, 0, 0, 1);
      chk("clr_no_write", en, 32'd0);
      idle(31);
      cycle(1, 1, 9, 32'hAAAA_5555, 0, 0, 0, 0);
      chk("post_clr_wb", en, 32'h0000_0200);

      // Reset on the tenth sweep cycle of a clear aborts and restarts
      cycle(1, 0, 0, 0, 0, 0, 0, 1);
      idle(9);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("abort_en_zero", en, 32'd0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      chk("restart_pulse", en, 32'h0000_0002);
      idle(31);

      // Random traffic, holding a stalled request stable until accepted
      wv = 0; av = 0; wa = 0; aa = 0; wd = 0; ad = 0;
      for (int i = 0; i < 600; i++) begin
         if (!g_wb_stall) begin
            wv = ($urandom_range(0, 9) < 6);
            wa = $urandom_range(0, 31);
            wd = $urandom;
         end
         if (!g_aux_stall) begin
            av = ($urandom_range(0, 9) < 5);
            aa = $urandom_range(0, 31);
            ad = $urandom;
         end
         c = ($urandom_range(0, 39) == 0);
         r = ($urandom_range(0, 149) != 0);
         cycle(r, wv, wa, wd, av, aa, ad, c);
      end
      chk("random_wb_seen", {31'd0, wb_writes > 10}, 32'd1);
      chk("random_aux_seen", {31'd0, aux_writes > 10}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
Write-port scheduler for the 32-entry register file built from per-bit enabled-flop banks. It arbitrates two write requesters onto the file's single write port: the pipeline writeback stage and an auxiliary port used by the multicycle unit and debug. It decodes the granted address into the one-hot per-register enable vector and drives the shared write data. It also runs a sequenced clear of r1..r31 after reset and on request, and never enables r0.

Parameters:
NREGS, 32, number of registers (enable vector width)
AW, 5, address width, log2(NREGS)
DW, 32, write data width
STARVE, 4, consecutive denied aux cycles before aux is forced to win

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (0 = reset on clk edge)
wb_valid  input  1  writeback request
wb_ready  output  1  writeback accepted this cycle when wb_valid=1
wb_addr  input  AW  writeback destination register
wb_data  input  DW  writeback data
aux_valid  input  1  auxiliary request
aux_ready  output  1  auxiliary accepted this cycle when aux_valid=1
aux_addr  input  AW  auxiliary destination register
aux_data  input  DW  auxiliary data
clr_req  input  1  single-cycle request to clear r1..r31
en  output  NREGS  one-hot register write enable, registered
wdata  output  DW  write data to all banks, registered
busy  output  1  1 while INIT or CLEAR sweep in progress

Behaviour:
- States are INIT, RUN and CLEAR. Sweep counter cnt is AW bits. Starvation counter scnt is 0..STARVE.
- Reset (reset=0 at clk edge):
  - state=INIT, cnt=1, scnt=0.
  - en=0, wdata=0, busy=1.
  - Reset mid-sweep or mid-transfer aborts it; no pending write is retained.
- INIT/CLEAR sweep:
  - Each cycle: en<=onehot(cnt), wdata<=0, cnt<=cnt+1.
  - When the sweep issues cnt=NREGS-1: next state RUN, cnt<=1.
  - Duration is exactly NREGS-1 cycles. en[0] is never asserted.
  - wb_ready=aux_ready=0 throughout; clr_req is ignored.
- busy: 1 in INIT and CLEAR, 0 in RUN. It falls in the cycle after the en[NREGS-1] pulse.
- RUN arbitration (combinational readies):
  - force = (scnt==STARVE).
  - If clr_req=1: both readies are 0 and the next state is CLEAR.
  - Otherwise: wb_ready = !force; aux_ready = force | !wb_valid.
  - Readies may be high while the corresponding valid is low.
  - Handshake occurs when valid & ready. At most one handshake per cycle.
- Write issue: a handshake at edge N gives en=onehot(addr), wdata=data, visible after edge N (1-cycle latency).
  - en is held for exactly one cycle.
  - With no handshake, en<=0 and wdata holds its last value.
- r0: addr=0 is still accepted (ready and handshake as normal), but en stays all-zero.
- scnt update in RUN, priority order:
  - aux handshake -> 0;
  - else aux_valid=0 -> 0;
  - else aux_valid & !aux_ready -> min(scnt+1, STARVE).
- scnt is held during CLEAR and reset to 0 by reset.
- Requester inputs must be held stable while valid=1 and ready=0.

Test Plan:
- Reset 3 cycles, release -> en pulses 0x00000002, 0x00000004, ... 0x80000000 on 31 consecutive cycles with wdata=0; busy=1 during the sweep, 0 on the next cycle; readies 0 until then.
- RUN, wb_valid=1, addr=5, data=0xDEADBEEF for 1 cycle -> wb_ready=1; next cycle en=0x00000020, wdata=0xDEADBEEF; following cycle en=0.
- wb and aux both valid continuously (wb addr=3, aux addr=7) -> wb wins 4 cycles; aux forced on the 5th (en=0x00000080), scnt resets and the pattern repeats.
- wb_valid=1, addr=0, data=0x1234 -> wb_ready=1, en stays 0 for all cycles; a following write to addr=1 yields en=0x00000002.
- RUN, clr_req=1 with wb_valid=1 in the same cycle -> wb_ready=0 and that request is not written; 31-cycle clear sweep follows; wb is accepted on the first RUN cycle after.
- reset asserted on the 10th sweep cycle of CLEAR -> en=0 next cycle; sweep restarts from en=0x00000002 after release.
